// File: rtl/ahb_usb_ep_slave.sv
// AHB-Lite slave bridging the bus to a USB endpoint byte FIFO and the RX/TX protocol engines.
// Optional feature macro USB_EP_IRQ_EN adds an irq output and an interrupt mask register at 0xA.
module ahb_usb_ep_slave #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned OCC_W      = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             hsel,
  input  logic [3:0]       haddr,
  input  logic [1:0]       hsize,
  input  logic [1:0]       htrans,
  input  logic             hwrite,
  input  logic [31:0]      hwdata,
  output logic [31:0]      hrdata,
  output logic             hready,
  output logic             hresp,
  input  logic [2:0]       rx_packet,
  input  logic             rx_data_ready,
  input  logic             rx_trans_active,
  input  logic             rx_error,
  input  logic             tx_trans_active,
  input  logic             tx_error,
  input  logic [OCC_W-1:0] buffer_occupancy,
  input  logic [7:0]       rx_data,
  output logic             get_rx_data,
  output logic             store_tx_data,
  output logic [7:0]       tx_data,
  output logic [2:0]       tx_packet,
`ifdef USB_EP_IRQ_EN
  output logic             irq,
`endif
  output logic             clear
);

  typedef enum logic [2:0] {StIdle, StPush, StPop, StPopDone, StErr1, StErr2} state_e;

  localparam logic [OCC_W-1:0] OccFull = OCC_W'(FIFO_DEPTH);

  state_e      state_q;
  logic [1:0]  lane_q;
  logic [2:0]  rem_q;
  logic        wr_pend_q;
  logic [3:0]  wr_be_q;
  logic [1:0]  wr_grp_q;
  logic        err_rx_q;
  logic        err_tx_q;
`ifdef USB_EP_IRQ_EN
  logic [9:0]  irq_mask_q;
`endif

  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        misalign;
  logic        wr_forbid;
  logic        addr_err;
  logic [3:0]  be;
  logic [2:0]  n_bytes;
  logic [9:0]  status;
  logic [15:0] occ_ext;
  logic [31:0] rd_word;
  logic [31:0] rd_data;
  logic        clr_rx;
  logic        clr_tx;
  logic        wr_txpkt;
  logic        wr_flush;
  logic        unused_htrans;

  assign unused_htrans = htrans[0];

  assign fifo_full     = (buffer_occupancy >= OccFull);
  assign fifo_empty    = (buffer_occupancy == '0);
  assign store_tx_data = (state_q == StPush) && !fifo_full;
  assign get_rx_data   = (state_q == StPop) && !fifo_empty;
  assign tx_data       = store_tx_data ? hwdata[{lane_q, 3'b000} +: 8] : 8'h00;
  assign hresp         = (state_q == StErr1) || (state_q == StErr2);

  always_comb begin
    hready = 1'b1;
    unique case (state_q)
      StPush:        hready = store_tx_data && (rem_q == 3'd1);
      StPop, StErr1: hready = 1'b0;
      default:       hready = 1'b1;
    endcase
  end

  assign accept = hsel && htrans[1] && hready;

  always_comb begin
    be      = 4'b0000;
    n_bytes = 3'd0;
    unique case (hsize)
      2'd0:    begin be = 4'b0001 << haddr[1:0];        n_bytes = 3'd1; end
      2'd1:    begin be = 4'b0011 << {haddr[1], 1'b0};  n_bytes = 3'd2; end
      2'd2:    begin be = 4'b1111;                      n_bytes = 3'd4; end
      default: begin be = 4'b0000;                      n_bytes = 3'd0; end
    endcase
  end

  assign misalign = ((hsize == 2'd1) && haddr[0]) || ((hsize == 2'd2) && (haddr[1:0] != 2'd0));

  // A write is refused if any byte it covers is read-only or reserved.
  always_comb begin
    wr_forbid = 1'b0;
    unique case (haddr[3:2])
      2'd1:    wr_forbid = be[0] | be[1];
`ifdef USB_EP_IRQ_EN
      2'd2:    wr_forbid = be[0] | be[1];
`else
      2'd2:    wr_forbid = |be;
`endif
      2'd3:    wr_forbid = be[2] | be[3];
      default: wr_forbid = 1'b0;
    endcase
  end

  assign addr_err = (hsize == 2'd3) || misalign || (hwrite && wr_forbid);

  assign status = {tx_trans_active | store_tx_data, rx_trans_active | get_rx_data, 3'b000,
                   rx_packet == 3'd4, rx_packet == 3'd3, rx_packet == 3'd2, rx_packet == 3'd1,
                   rx_data_ready};
  assign occ_ext = 16'(buffer_occupancy);

  always_comb begin
    rd_word = 32'h0;
    unique case (haddr[3:2])
      2'd1:    rd_word = {7'b0, err_tx_q, 7'b0, err_rx_q, 6'b0, status};
`ifdef USB_EP_IRQ_EN
      2'd2:    rd_word = {6'b0, irq_mask_q, occ_ext};
`else
      2'd2:    rd_word = {16'b0, occ_ext};
`endif
      2'd3:    rd_word = {29'b0, tx_packet};
      default: rd_word = 32'h0;
    endcase
  end

  assign rd_data = rd_word & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

  // Register writes take effect in the data phase, when hwdata is valid.
  assign clr_rx   = wr_pend_q && (wr_grp_q == 2'd1) && wr_be_q[2] && hwdata[16];
  assign clr_tx   = wr_pend_q && (wr_grp_q == 2'd1) && wr_be_q[3] && hwdata[24];
  assign wr_txpkt = wr_pend_q && (wr_grp_q == 2'd3) && wr_be_q[0];
  assign wr_flush = wr_pend_q && (wr_grp_q == 2'd3) && wr_be_q[1] && hwdata[8];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      lane_q     <= 2'd0;
      rem_q      <= 3'd0;
      wr_pend_q  <= 1'b0;
      wr_be_q    <= 4'b0;
      wr_grp_q   <= 2'd0;
      err_rx_q   <= 1'b0;
      err_tx_q   <= 1'b0;
      hrdata     <= 32'h0;
      tx_packet  <= 3'd0;
      clear      <= 1'b0;
`ifdef USB_EP_IRQ_EN
      irq_mask_q <= 10'h0;
      irq        <= 1'b0;
`endif
    end else begin
      wr_pend_q <= 1'b0;
      clear     <= wr_flush;
      err_rx_q  <= (err_rx_q & ~clr_rx) | rx_error;
      err_tx_q  <= (err_tx_q & ~clr_tx) | tx_error;
      if (wr_txpkt) begin
        tx_packet <= hwdata[2:0];
      end else if (tx_trans_active) begin
        tx_packet <= 3'd0;
      end
`ifdef USB_EP_IRQ_EN
      if (wr_pend_q && (wr_grp_q == 2'd2) && wr_be_q[2]) irq_mask_q[7:0] <= hwdata[23:16];
      if (wr_pend_q && (wr_grp_q == 2'd2) && wr_be_q[3]) irq_mask_q[9:8] <= hwdata[25:24];
      irq <= (|(status & irq_mask_q)) | err_rx_q | err_tx_q;
`endif

      unique case (state_q)
        StPush: begin
          if (store_tx_data) begin
            lane_q <= lane_q + 2'd1;
            rem_q  <= rem_q - 3'd1;
          end
        end
        StPop: begin
          if (get_rx_data) begin
            hrdata[{lane_q, 3'b000} +: 8] <= rx_data;
            lane_q <= lane_q + 2'd1;
            rem_q  <= rem_q - 3'd1;
            if (rem_q == 3'd1) state_q <= StPopDone;
          end
        end
        StErr1:  state_q <= StErr2;
        default: ;
      endcase

      // Every cycle that completes with hready high may overlap a new address phase.
      if (hready) begin
        state_q <= StIdle;
        if (accept) begin
          hrdata <= 32'h0;
          if (addr_err) begin
            state_q <= StErr1;
          end else if (haddr[3:2] == 2'd0) begin
            lane_q  <= haddr[1:0];
            rem_q   <= n_bytes;
            state_q <= hwrite ? StPush : StPop;
          end else if (hwrite) begin
            wr_pend_q <= 1'b1;
            wr_be_q   <= be;
            wr_grp_q  <= haddr[3:2];
          end else begin
            hrdata <= rd_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_usb_ep_slave.sv
// Directed self-checking bench for ahb_usb_ep_slave (default build, FIFO_DEPTH=64).
module tb_ahb_usb_ep_slave;

  localparam int unsigned FIFO_DEPTH = 64;
  localparam int unsigned OCC_W      = 7;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             hsel;
  logic [3:0]       haddr;
  logic [1:0]       hsize;
  logic [1:0]       htrans;
  logic             hwrite;
  logic [31:0]      hwdata;
  logic [31:0]      hrdata;
  logic             hready;
  logic             hresp;
  logic [2:0]       rx_packet;
  logic             rx_data_ready;
  logic             rx_trans_active;
  logic             rx_error;
  logic             tx_trans_active;
  logic             tx_error;
  logic [OCC_W-1:0] occ;
  logic [7:0]       rx_data;
  logic             get_rx_data;
  logic             store_tx_data;
  logic [7:0]       tx_data;
  logic [2:0]       tx_packet;
  logic             clear;
`ifdef USB_EP_IRQ_EN
  logic             irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_w [4];

  always #5 clk = ~clk;

  ahb_usb_ep_slave #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .OCC_W      (OCC_W)
  ) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .hsel             (hsel),
    .haddr            (haddr),
    .hsize            (hsize),
    .htrans           (htrans),
    .hwrite           (hwrite),
    .hwdata           (hwdata),
    .hrdata           (hrdata),
    .hready           (hready),
    .hresp            (hresp),
    .rx_packet        (rx_packet),
    .rx_data_ready    (rx_data_ready),
    .rx_trans_active  (rx_trans_active),
    .rx_error         (rx_error),
    .tx_trans_active  (tx_trans_active),
    .tx_error         (tx_error),
    .buffer_occupancy (occ),
    .rx_data          (rx_data),
    .get_rx_data      (get_rx_data),
    .store_tx_data    (store_tx_data),
    .tx_data          (tx_data),
    .tx_packet        (tx_packet),
`ifdef USB_EP_IRQ_EN
    .irq              (irq),
`endif
    .clear            (clear)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [3:0] a, input logic [1:0] sz, input logic wr);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hsize  = sz;
    hwrite = wr;
    step();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [1:0] sz, input logic [31:0] d);
    addr_phase(a, sz, 1'b1);
    hwdata = d;
    step();
  endtask

  task automatic reg_read(input string tag, input logic [3:0] a, input logic [1:0] sz,
                          input logic [31:0] exp);
    addr_phase(a, sz, 1'b0);
    #4;
    check(tag, {hrdata[31:1], hrdata[0] & hready}, exp);
    step();
  endtask

  // {hresp, hready, get_rx_data, store_tx_data} over ERR1, ERR2 and the idle cycle after.
  task automatic err_seq(input string tag);
    #4;
    check({tag, "_err1"}, 32'({hresp, hready, get_rx_data, store_tx_data}), 32'b1000);
    step();
    #4;
    check({tag, "_err2"}, 32'({hresp, hready, get_rx_data, store_tx_data}), 32'b1100);
    step();
    #4;
    check({tag, "_idle"}, 32'({hresp, hready}), 32'b01);
  endtask

  initial begin
    exp_w = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    n_rst = 1'b0; hsel = 1'b0; haddr = 4'h0; hsize = 2'd0; htrans = 2'b00; hwrite = 1'b0;
    hwdata = 32'h0; rx_packet = 3'd0; rx_data_ready = 1'b0; rx_trans_active = 1'b0;
    rx_error = 1'b0; tx_trans_active = 1'b0; tx_error = 1'b0; occ = '0; rx_data = 8'h0;
    #12;
    check("rst_hready", 32'(hready), 32'h1);
    check("rst_hresp", 32'(hresp), 32'h0);
    check("rst_hrdata", hrdata, 32'h0);
    check("rst_strobes", 32'({store_tx_data, get_rx_data, clear}), 32'h0);
    check("rst_tx", 32'({tx_packet, tx_data}), 32'h0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    step();

    // Word push, no stalls.
    addr_phase(4'h0, 2'd2, 1'b1);
    hwdata = 32'hDDCCBBAA;
    for (int i = 0; i < 4; i++) begin
      #4;
      check("w4_store", 32'(store_tx_data), 32'h1);
      check("w4_data", 32'(tx_data), 32'(exp_w[i]));
      check("w4_hready", 32'(hready), 32'(i == 3));
      step();
    end
    #4;
    check("w4_after", 32'(store_tx_data), 32'h0);
    step();

    // Byte push into a full FIFO.
    addr_phase(4'h2, 2'd0, 1'b1);
    hwdata = 32'h00EE0000;
    occ    = 7'd64;
    for (int i = 0; i < 3; i++) begin
      #4;
      check("full_hold", 32'({store_tx_data, hready}), 32'b00);
      step();
    end
    occ = 7'd63;
    #4;
    check("full_push", 32'({store_tx_data, hready, tx_data}), 32'h3EE);
    step();
    occ = 7'd64;
    #4;
    check("full_after", 32'(store_tx_data), 32'h0);
    step();
    occ = '0;

    // Half pop of 0x11, 0x22.
    occ = 7'd2;
    rx_data = 8'h11;
    addr_phase(4'h0, 2'd1, 1'b0);
    #4;
    check("pop1", 32'({get_rx_data, hready}), 32'b10);
    step();
    occ = 7'd1;
    rx_data = 8'h22;
    #4;
    check("pop2", 32'({get_rx_data, hready}), 32'b10);
    step();
    occ = '0;
    rx_data = 8'h00;
    #4;
    check("pop_done_rdy", 32'({get_rx_data, hready}), 32'b01);
    check("pop_done_data", hrdata, 32'h00002211);
    step();

    // Byte pop stalls on an empty FIFO, then completes.
    addr_phase(4'h0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #4;
      check("empty_hold", 32'({get_rx_data, hready}), 32'b00);
      step();
    end
    occ = 7'd1;
    rx_data = 8'h5A;
    #4;
    check("empty_pop", 32'({get_rx_data, hready}), 32'b10);
    step();
    occ = '0;
    #4;
    check("empty_done", hrdata, 32'h0000005A);
    step();

    // Status register.
    rx_data_ready = 1'b1;
    rx_packet = 3'd2;
    tx_trans_active = 1'b1;
    reg_read("status", 4'h4, 2'd1, 32'h00000205);
    tx_trans_active = 1'b0;

    // Error responses.
    addr_phase(4'h4, 2'd1, 1'b1);
    hwdata = 32'h0000FFFF;
    err_seq("wr_status");
    step();
    reg_read("status_kept", 4'h4, 2'd1, 32'h00000005);
    addr_phase(4'h1, 2'd1, 1'b0);
    err_seq("misalign");
    step();
    addr_phase(4'hC, 2'd2, 1'b1);
    hwdata = 32'h00000007;
    err_seq("wr_reserved");
    step();
    reg_read("txpkt_kept", 4'hC, 2'd0, 32'h0);
    occ = 7'd1;
    addr_phase(4'h0, 2'd3, 1'b0);
    err_seq("hsize3");
    step();
    occ = '0;
    addr_phase(4'hA, 2'd0, 1'b1);
`ifdef USB_EP_IRQ_EN
    hwdata = 32'h0;
    step();
`else
    err_seq("wr_0xa");
    step();
`endif

    // Sticky error bits.
    rx_error = 1'b1;
    step();
    rx_error = 1'b0;
    reg_read("err_set", 4'h6, 2'd1, 32'h00010000);
    reg_write(4'h6, 2'd1, 32'h00010000);
    reg_read("err_clr", 4'h6, 2'd1, 32'h0);
    rx_error = 1'b1;
    step();
    rx_error = 1'b0;
    addr_phase(4'h6, 2'd1, 1'b1);
    hwdata = 32'h00010000;
    rx_error = 1'b1;
    step();
    rx_error = 1'b0;
    reg_read("err_set_wins", 4'h6, 2'd1, 32'h00010000);
    tx_error = 1'b1;
    step();
    tx_error = 1'b0;
    reg_read("err_tx", 4'h7, 2'd0, 32'h01000000);
    reg_write(4'h6, 2'd1, 32'h01010000);
    reg_read("err_clr_both", 4'h4, 2'd2, 32'h00000005);

    // Occupancy register.
    occ = 7'h2A;
    reg_read("occ", 4'h8, 2'd2, 32'h0000002A);
    occ = '0;

    // TX packet request and self-clear.
    reg_write(4'hC, 2'd0, 32'h00000003);
    #4;
    check("txpkt_set", 32'(tx_packet), 32'h3);
    step();
    #4;
    check("txpkt_hold", 32'(tx_packet), 32'h3);
    step();
    tx_trans_active = 1'b1;
    #4;
    check("txpkt_seen", 32'(tx_packet), 32'h3);
    step();
    #4;
    check("txpkt_cleared", 32'(tx_packet), 32'h0);
    tx_trans_active = 1'b0;
    step();

    // Flush pulse.
    addr_phase(4'hD, 2'd0, 1'b1);
    hwdata = 32'h00000100;
    #4;
    check("clear_dphase", 32'(clear), 32'h0);
    step();
    #4;
    check("clear_pulse", 32'(clear), 32'h1);
    step();
    #4;
    check("clear_end", 32'(clear), 32'h0);
    step();

    // Reset during a push.
    addr_phase(4'h0, 2'd2, 1'b1);
    hwdata = 32'h44332211;
    #4;
    check("rst_push1", 32'({store_tx_data, tx_data}), 32'h111);
    step();
    #1;
    n_rst = 1'b0;
    #1;
    check("rst_mid", 32'({store_tx_data, hready, hresp, tx_data}), 32'h200);
    step();
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4;
      check("rst_no_push", 32'({store_tx_data, hready}), 32'b01);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
